// File: rtl/imm_ext_pkg.sv
// Shared immediate-extension mode encoding.
// Used by the decoder and imm_extend_stage.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender.
// Zero, sign, upper-placement and branch-offset forms.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8,
  parameter int SHAMT = 1
) (
  input  logic [IN_W-1:0]  imm,
  input  mode_e            mode,
  output logic [OUT_W-1:0] ext
);

  localparam int E = OUT_W - IN_W;

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  always_comb begin
    zext = '0;
    zext[IN_W-1:0] = imm;
    sext = {OUT_W{imm[IN_W-1]}};
    sext[IN_W-1:0] = imm;
  end

  always_comb begin
    ext = zext;
    unique case (mode)
      MODE_ZERO:   ext = zext;
      MODE_SIGN:   ext = sext;
      MODE_UPPER:  ext = zext << E;
      MODE_BRANCH: ext = sext << SHAMT;
      default:     ext = zext;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Pipelined immediate extender with 2-entry skid buffer.
// Optional transfer counter: define IMM_EXT_STATS_EN.
module imm_extend_stage
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8,
  parameter int SHAMT = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef IMM_EXT_STATS_EN
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] ext_count
`else
  output logic [OUT_W-1:0] out_data
`endif
);

  logic [OUT_W-1:0] ext;
  logic             m_valid;
  logic [OUT_W-1:0] m_data;
  logic             s_valid;
  logic [OUT_W-1:0] s_data;
  logic             rdy_q;
  logic             in_xfer;
  logic             out_xfer;

  imm_ext_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHAMT(SHAMT)
  ) u_core (
    .imm (in_imm),
    .mode(mode_e'(in_mode)),
    .ext (ext)
  );

  assign in_xfer  = in_valid & rdy_q & ~rst;
  assign out_xfer = m_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
      rdy_q   <= 1'b1;
    end else if (!m_valid || out_xfer) begin
      // M frees up: S (oldest) moves first, new word backfills S
      if (s_valid) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        s_valid <= in_xfer;
        rdy_q   <= ~in_xfer;
        if (in_xfer) s_data <= ext;
      end else begin
        m_valid <= in_xfer;
        rdy_q   <= 1'b1;
        if (in_xfer) m_data <= ext;
      end
    end else if (in_xfer) begin
      s_valid <= 1'b1;
      s_data  <= ext;
      rdy_q   <= 1'b0;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = m_valid;
  assign out_data  = m_data;

`ifdef IMM_EXT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) ext_count <= '0;
    else if (in_xfer) ext_count <= ext_count + 1'b1;
  end
`endif

endmodule

// File: doc/imm_extend_stage.md
Name: imm_extend_stage

Overview:
- Parametrised, pipelined immediate extender for the 8-bit MIPS datapath. It replaces the fixed 3-to-5-bit zero-extender.
- Takes an IN_W-bit immediate plus a 2-bit mode and produces an OUT_W-bit operand: zero-extend, sign-extend, upper-placement, or branch offset (sign-extend then shift).
- Registered output with a valid/ready handshake and a 2-entry skid buffer, so the stage sits between decode and ALU-operand select without a combinational ready path.

Parameters:
- IN_W, 3, immediate input width; 1 <= IN_W <= OUT_W.
- OUT_W, 8, extended output width.
- SHAMT, 1, left shift applied in BRANCH mode; 0 <= SHAMT < OUT_W.
- CNT_W, 16, width of the transfer counter (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  stage can accept; registered.
- in_imm  in  IN_W  raw immediate.
- in_mode  in  2  00 ZERO, 01 SIGN, 10 UPPER, 11 BRANCH.
- out_valid  out  1  output word present.
- out_ready  in  1  consumer accepts.
- out_data  out  OUT_W  extended immediate.
- ext_count  out  CNT_W  accepted-transfer count; present only with IMM_EXT_STATS_EN.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high. All state updates on the rising edge of `clk`.
- Reset values: out_valid=0, out_data=0, in_ready=1, skid register empty, ext_count=0. While rst=1, inputs are ignored and no transfer completes.
- Extension (combinational, applied on accept; E = OUT_W-IN_W):
  - ZERO: {E zeros, imm}.
  - SIGN: {E copies of imm[IN_W-1], imm}.
  - UPPER: imm << E. Low E bits are zero; identity when E=0.
  - BRANCH: SIGN result << SHAMT, truncated to OUT_W. Shifted-out MSBs are discarded; no overflow flag.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_data/out_valid must stay stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle from input accept to out_valid when the stage is empty. Full throughput (1 word/cycle) when out_ready=1 continuously.
- Storage: main register M (drives out_*) and skid register S.
  - M empty, or M transferring this cycle: the accepted word loads into M (from S first if S full, then S takes the new input).
  - M full and not transferring: the accepted word goes to S; in_ready falls the next cycle.
  - in_ready = !S_full, registered.
- Both registers full: in_ready=0. The following out_transfer moves S to M and raises in_ready on the next cycle.
- Simultaneous input and output transfer with S empty: M is replaced by the new word and out_valid stays 1.
- Ordering: strictly FIFO. No word is dropped or duplicated.
- Reset mid-operation: both registers are emptied in the reset cycle. Words in flight are discarded. in_ready=1 on the cycle after rst deasserts.

Optional Feature:
- Macro: IMM_EXT_STATS_EN.
- Defined: port ext_count exists. It increments by 1 on every input transfer, wraps at 2^CNT_W to 0, and resets to 0.
- Undefined: no port, no counter logic. Datapath behaviour is identical in both builds.

Decomposition:
- Package imm_ext_pkg: 2-bit mode type and constants MODE_ZERO, MODE_SIGN, MODE_UPPER, MODE_BRANCH. The top level shares these with the decoder.
- Sub-module imm_ext_core: purely combinational extension (IN_W, OUT_W, SHAMT). The stage instantiates it once ahead of the skid logic.

Test Plan (IN_W=3, OUT_W=8, SHAMT=1):
- Mode coverage, one word each, out_ready=1: imm=3'b101 ZERO -> 8'h05; SIGN -> 8'hFD; UPPER -> 8'hA0; imm=3'b110 BRANCH -> 8'hFC. Each appears 1 cycle after accept.
- Streaming: 8 back-to-back words, out_ready=1 -> 8 output beats on consecutive cycles, in_ready stays 1, order preserved.
- Backpressure: in_valid=1 continuously, out_ready=0 for 3 cycles -> exactly 2 words accepted, in_ready=0 from the cycle after the 2nd accept, out_data stable. Release out_ready -> words drain in order, none lost.
- Simultaneous: M full, S empty, in_valid=1 and out_ready=1 in the same cycle -> old word leaves, new word in M next cycle, out_valid remains 1.
- Reset mid-operation: both registers full, assert rst 1 cycle -> next cycle out_valid=0, out_data=0, in_ready=1. The first post-reset word emerges with 1-cycle latency.
- IMM_EXT_STATS_EN with CNT_W=2: 5 accepted words -> ext_count sequence 1, 2, 3, 0, 1; rst returns it to 0.
